// File: rtl/button_press_counter.sv
// Pushbutton front end: two-flop synchroniser, debounce FSM, press/release/long-press
// event pulses and a wrapping press counter for the LED/counter display logic.
module button_press_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             clr_count,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HCNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(LONG_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDbPress,
        StHeld,
        StDbRelease
    } state_e;

    // Synchroniser flops; only btn_s2_q is seen by the FSM.
    logic btn_s1_q;
    logic btn_s2_q;

    state_e             state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
    logic               long_done_q, long_done_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               count_inc;
    logic               hold_active;
    logic [HCNT_W-1:0]  hcnt_next;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // FSM, debounce/hold counters and registered event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Press counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Hold timer keeps running through release debounce so a long press can still
    // complete while a release is being qualified.
    always_comb begin
        hold_active = (state_q == StHeld) || (state_q == StDbRelease);
        hcnt_next   = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HCNT_ONE;
    end

    // Next-state logic: debounce in both directions, long-press detection.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_inc   = 1'b0;

        // Fires on the cycle the hold count reaches LONG_CYCLES-1, i.e. LONG_CYCLES-1
        // cycles after press_pulse; long_done limits it to once per press.
        if (hold_active) begin
            hcnt_d = hcnt_next;
            if ((hcnt_next == HCNT_FIRE) && !long_done_q) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (btn_s2_q) begin
                    state_d = StDbPress;
                    dcnt_d  = '0;
                end
            end
            StDbPress: begin
                if (!btn_s2_q) begin
                    state_d = StIdle;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d     = StHeld;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    count_inc   = 1'b1;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            StHeld: begin
                if (!btn_s2_q) begin
                    state_d = StDbRelease;
                    dcnt_d  = '0;
                end
            end
            StDbRelease: begin
                if (btn_s2_q) begin
                    // Release bounce: stay pressed.
                    state_d = StHeld;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = StIdle;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_ONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Clear takes priority, then the press in the same cycle still counts.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = count_inc ? CNT_ONE : '0;
        end else if (count_inc) begin
            count_d = count_q + CNT_ONE;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign press_count   = count_q;

    // Press and release events are mutually exclusive and each lasts one cycle.
    a_press_release_excl: assert property (@(posedge clk) disable iff (!rst)
        !(press_pulse && release_pulse));
    a_press_single: assert property (@(posedge clk) disable iff (!rst)
        press_pulse |=> !press_pulse);
    a_release_single: assert property (@(posedge clk) disable iff (!rst)
        release_pulse |=> !release_pulse);

endmodule

// File: tb/tb_button_press_counter.sv
// Bench for button_press_counter: a directed table for a clean press, hand-written corner
// sequences, and random bouncy input, all checked against a run-length reference model.
module tb_button_press_counter;

    localparam int unsigned D = 4;
    localparam int unsigned L = 16;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn = 1'b0;
    logic         clr_count = 1'b0;
    logic         btn_level;
    logic         press_pulse;
    logic         release_pulse;
    logic         long_pulse;
    logic [W-1:0] press_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_press_counter #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .clr_count    (clr_count),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    // Reference model: the level flips once the synchronised input has disagreed with it
    // for D+1 consecutive samples; long fires L-1 cycles after the press while still held.
    logic         m_s1, m_s2, m_level, m_press, m_release, m_long;
    int           m_run, m_since;
    logic [W-1:0] m_count;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_release = 0; m_long = 0;
        m_run = 0; m_since = 0; m_count = '0;
    endtask

    task automatic model_step();
        logic s2v;
        logic inc;
        if (!rst) begin
            model_reset();
            return;
        end
        s2v = m_s2;
        m_s2 = m_s1;
        m_s1 = btn;
        m_press = 0; m_release = 0; m_long = 0; inc = 0;
        if (m_level) begin
            m_since++;
            if (m_since == int'(L) - 1) m_long = 1;
        end
        if (s2v != m_level) m_run++;
        else m_run = 0;
        if (m_run == int'(D) + 1) begin
            m_run = 0;
            m_level = !m_level;
            if (m_level) begin
                m_press = 1; m_since = 0; inc = 1;
            end else begin
                m_release = 1;
            end
        end
        if (clr_count) m_count = inc ? W'(1) : W'(0);
        else if (inc) m_count = m_count + W'(1);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_level", int'(btn_level), int'(m_level));
        check("model_press", int'(press_pulse), int'(m_press));
        check("model_release", int'(release_pulse), int'(m_release));
        check("model_long", int'(long_pulse), int'(m_long));
        check("model_count", int'(press_count), int'(m_count));
    endtask

    // Drive inputs after a falling edge, clock once, sample on the next falling edge.
    task automatic tick(input logic b, input logic c);
        btn = b;
        clr_count = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // Assert reset right now and check outputs clear without waiting for a clock.
    task automatic reset_now(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_level"}, int'(btn_level), 0);
        check({tag, "_press"}, int'(press_pulse), 0);
        check({tag, "_release"}, int'(release_pulse), 0);
        check({tag, "_long"}, int'(long_pulse), 0);
        check({tag, "_count"}, int'(press_count), 0);
        model_reset();
    endtask

    typedef struct {
        logic         b;
        logic         c;
        logic         level;
        logic         press;
        logic         rel;
        logic         lng;
        logic [W-1:0] count;
    } vec_t;

    vec_t tbl[28];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nr, nl, ip, il, first;

        // Row n-1 describes clock edge n after reset release: btn sampled high on
        // edges 10..19, so press lands on edge 16 and release on edge 26.
        for (int n = 1; n <= 28; n++) begin
            tbl[n-1].b     = (n >= 10 && n <= 19);
            tbl[n-1].c     = 1'b0;
            tbl[n-1].level = (n >= 16 && n < 26);
            tbl[n-1].press = (n == 16);
            tbl[n-1].rel   = (n == 26);
            tbl[n-1].lng   = 1'b0;
            tbl[n-1].count = (n >= 16) ? W'(1) : W'(0);
        end

        #2;
        reset_now("rst_init");
        tick(0, 0);
        tick(0, 0);
        rst = 1'b1;

        // 1: clean press from the table.
        for (int i = 0; i < 28; i++) begin
            tick(tbl[i].b, tbl[i].c);
            check("tbl_level", int'(btn_level), int'(tbl[i].level));
            check("tbl_press", int'(press_pulse), int'(tbl[i].press));
            check("tbl_release", int'(release_pulse), int'(tbl[i].rel));
            check("tbl_long", int'(long_pulse), int'(tbl[i].lng));
            check("tbl_count", int'(press_count), int'(tbl[i].count));
        end

        // 2a: three-cycle glitch is rejected.
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0);
            np += int'(press_pulse) + int'(release_pulse);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            np += int'(press_pulse) + int'(release_pulse);
        end
        check("glitch_events", np, 0);
        check("glitch_level", int'(btn_level), 0);
        check("glitch_count", int'(press_count), 1);

        // 2b: bounce during release yields exactly one release event.
        for (int i = 0; i < 12; i++) tick(1, 0);
        nr = 0;
        for (int i = 0; i < 2; i++) begin tick(0, 0); nr += int'(release_pulse); end
        tick(1, 0);
        nr += int'(release_pulse);
        for (int i = 0; i < 12; i++) begin tick(0, 0); nr += int'(release_pulse); end
        check("bounce_release_count", nr, 1);
        check("bounce_press_count", int'(press_count), 2);

        // 3: long press fires once, L-1 cycles after the press event.
        nl = 0; nr = 0; ip = -1; il = -1;
        for (int i = 0; i < 45; i++) begin
            tick(i < 30, 0);
            if (press_pulse && ip < 0) ip = i;
            if (long_pulse) begin nl++; if (il < 0) il = i; end
            nr += int'(release_pulse);
        end
        check("long_once", nl, 1);
        check("long_delay", il - ip, int'(L) - 1);
        check("long_release", nr, 1);

        // 4: clear, then 16 presses wrap the 4-bit count back to zero.
        tick(0, 1);
        check("clear_count", int'(press_count), 0);
        for (int p = 1; p <= 16; p++) begin
            for (int i = 0; i < 8; i++) tick(1, 0);
            for (int i = 0; i < 8; i++) tick(0, 0);
            if (p == 15) check("wrap_15", int'(press_count), 15);
        end
        check("wrap_0", int'(press_count), 0);
        for (int i = 0; i < 8; i++) tick(1, 0);
        for (int i = 0; i < 8; i++) tick(0, 0);
        // Clear lands on the press edge: count becomes 1, not 2.
        for (int i = 0; i < 10; i++) tick(1, i == 6);
        check("clr_with_press", int'(press_count), 1);
        for (int i = 0; i < 8; i++) tick(0, 0);

        // 5a: reset while debouncing a press, released with the button still down.
        for (int i = 0; i < 3; i++) tick(1, 0);
        reset_now("rst_dbpress");
        tick(1, 0);
        tick(1, 0);
        rst = 1'b1;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0);
            if (press_pulse && first < 0) first = i;
        end
        check("rst_release_latency", first, 6);
        check("rst_release_count", int'(press_count), 1);

        // 5b: reset while held.
        for (int i = 0; i < 5; i++) tick(1, 0);
        reset_now("rst_held");
        tick(0, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick(0, 0);

        // Random bouncy input with occasional clears.
        for (int s = 0; s < 250; s++) begin
            logic b;
            int len;
            b = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) tick(b, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
